pixel_io_ctrl: RTL and testbench
================================

# pixel_io_ctrl

Host-side transfer controller that sits directly behind the chip's I/O pad ring. It converts an asynchronous 4-phase req/ack host protocol on an 8-bit half-duplex bidirectional pad bus into valid/ready streams for the edge-detection core. Pixels flow in; edge results flow out. It drives the enable of the bidirectional data pads and the ack output pad, and it synchronises the req and dir input pads.

## Interface
- `DW`, 8: data bus and stream width.
- `SYNC_STAGES`, 2: flops in each input synchroniser; minimum 2.
- `SETUP_CYC`, 2: cycles that read data is driven before ack rises; minimum 1.

Ports:
- `clk`  in  1  core clock. One clock only.
- `reset`  in  1  asynchronous, active-high reset.
- `req_pad`  in  1  host request, from input pad. Asynchronous.
- `dir_pad`  in  1  host direction, from input pad. 0 = host writes pixel, 1 = host reads result. Asynchronous.
- `ack_pad`  out  1  ack to the output pad.
- `bus_in`  in  DW  DataIn of the bidirectional data pads.
- `bus_out`  out  DW  DataOut of the bidirectional data pads.
- `bus_en`  out  1  EN of all data pads. 1 = chip drives the bus.
- `pix_data`  out  DW  pixel to the core.
- `pix_valid`  out  1  pixel valid.
- `pix_ready`  in  1  core accepts the pixel.
- `res_data`  in  DW  result from the core.
- `res_valid`  in  1  result valid.
- `res_ready`  out  1  controller accepts the result.
- `proto_err`  out  1  sticky flag. Set when req falls before ack. Cleared only by reset.

## Operation
- `req_pad` and `dir_pad` each pass through a `SYNC_STAGES`-deep synchroniser, giving `req_s` and `dir_s`. `bus_in` is not synchronised; the host holds it stable from before req rises until ack rises.
- FSM states: IDLE, WR_HOLD, RD_WAIT, RD_SETUP, ACK_HI.
- IDLE:
  - On `req_s`=1 and `dir_s`=0: register `bus_in` into `pix_data`, set `pix_valid`, go to WR_HOLD.
  - On `req_s`=1 and `dir_s`=1: go to RD_WAIT.
- WR_HOLD:
  - `pix_valid` and `pix_data` stay stable until `pix_valid`&`pix_ready`.
  - On that handshake edge: clear `pix_valid`, go to ACK_HI.
  - If `req_s` has already fallen, set `proto_err` and go to IDLE instead; the pixel is still delivered.
- RD_WAIT:
  - `res_ready`=1.
  - On `res_valid`&`res_ready`: register `res_data` into `bus_out`, set `bus_en`, clear the setup counter, go to RD_SETUP.
  - If `req_s` falls first: set `proto_err`, return to IDLE; no result is consumed.
- RD_SETUP: count `SETUP_CYC` cycles with the bus driven, then go to ACK_HI.
- ACK_HI:
  - `ack_pad`=1. `bus_en` is held if entered from a read.
  - When `req_s`=0: clear `ack_pad` and `bus_en` on the same edge, go to IDLE.
- `dir_s` is sampled only in IDLE; changes at any other time are ignored.
- Reset mid-transfer: FSM returns to IDLE; all outputs take their reset values immediately (asynchronous). Any in-flight pixel or result is dropped.

## Timing
- Reset values: `ack_pad`=0, `bus_en`=0, `bus_out`=0, `pix_data`=0, `pix_valid`=0, `res_ready`=0, `proto_err`=0. Synchroniser flops reset to 0.
- All outputs are registered; none is combinational from inputs.
- Write path:
  - `pix_valid` rises `SYNC_STAGES`+1 edges after the `req_pad` rise is captured.
  - `ack_pad` rises 1 edge after the pixel handshake.
- Read path:
  - `res_ready` rises `SYNC_STAGES`+1 edges after the req rise.
  - `bus_en` rises 1 edge after the result handshake.
  - `ack_pad` rises `SETUP_CYC` edges after `bus_en`.
- Release: `ack_pad` and `bus_en` fall together, `SYNC_STAGES`+1 edges after the `req_pad` fall.
- Bus turnaround: the chip never drives while ack=0 and IDLE. The host must not drive the bus until it sees ack low.
- Back-to-back transfers: a new req is acted on only from IDLE, so the minimum host cycle time is two synchroniser latencies plus the handshake time.

## Structure
- Package `pixel_io_pkg`:
  - state enum `pio_state_t`;
  - default constants `PIO_DW`, `PIO_SYNC_STAGES`, `PIO_SETUP_CYC`.
- Sub-module `io_sync`: a parameterised-depth, 1-bit, async-reset flop chain. It is instantiated twice, for req and dir.

## Test plan
- Write: dir=0, bus=0xA5, req rises; `pix_ready`=1 → `pix_data`=0xA5, `pix_valid` for 1 cycle at edge 3; `ack_pad`=1 at edge 4; req falls → ack=0 three edges later.
- Write backpressure: `pix_ready` held 0 for 10 cycles → `pix_valid` and 0xA5 stay stable, `ack_pad` stays 0; ack rises 1 edge after ready.
- Read: dir=1, req rises, `res_valid`=1 with `res_data`=0x3C → `bus_en`=1 and `bus_out`=0x3C, `ack_pad`=1 two edges later; req falls → `bus_en` and `ack_pad` fall on the same edge.
- Read abort: dir=1, req rises, `res_valid`=0, req falls after 6 cycles → IDLE, `proto_err`=1, `res_ready`=0, `bus_en` never rises.
- Reset during RD_SETUP → `bus_en`, `ack_pad` and `proto_err` are 0 immediately; a following write of 0x01 completes normally.
- Dir toggled while in ACK_HI → no effect; the next transfer uses the dir value sampled in IDLE.

Source files
------------

// File: rtl/pixel_io_pkg.sv
// Shared definitions for the pad-side transfer controller.
// Holds the FSM state type and the default parameter values used by
// pixel_io_ctrl and its testbench.
package pixel_io_pkg;

    localparam int PIO_DW          = 8;
    localparam int PIO_SYNC_STAGES = 2;
    localparam int PIO_SETUP_CYC   = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_HOLD  = 3'd1,
        RD_WAIT  = 3'd2,
        RD_SETUP = 3'd3,
        ACK_HI   = 3'd4
    } pio_state_t;

endpackage

// File: rtl/io_sync.sv
// Single-bit input synchroniser: a STAGES-deep chain of flops with
// asynchronous active-high reset to 0.
// Ports:
//   clk_i - destination clock
//   rst_i - asynchronous active-high reset
//   d_i   - asynchronous input from the pad
//   q_o   - synchronised output (last flop of the chain)
module io_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pixel_io_ctrl.sv
// Host-side transfer controller behind the pad ring. Converts the host's
// asynchronous 4-phase req/ack protocol on a half-duplex 8-bit pad bus into
// valid/ready streams: pixels in (dir=0), edge results out (dir=1).
//
// Stream handshakes: a beat transfers on a rising clk edge where valid and
// ready are both 1; the producer holds valid and data stable until then.
//
// Ports:
//   clk, reset          - core clock, asynchronous active-high reset
//   req_pad, dir_pad    - asynchronous host request / direction pads
//   ack_pad             - registered ack to the output pad
//   bus_in/bus_out      - data pad DataIn / DataOut
//   bus_en              - data pad output enable (1 = chip drives)
//   pix_data/valid/ready- pixel stream to the core
//   res_data/valid/ready- result stream from the core
//   proto_err           - sticky: host dropped req before ack
//   dbg_state           - current FSM state, for observation only
module pixel_io_ctrl
    import pixel_io_pkg::*;
#(
    parameter int DW          = PIO_DW,
    parameter int SYNC_STAGES = PIO_SYNC_STAGES,
    parameter int SETUP_CYC   = PIO_SETUP_CYC
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_pad,
    input  logic          dir_pad,
    output logic          ack_pad,
    input  logic [DW-1:0] bus_in,
    output logic [DW-1:0] bus_out,
    output logic          bus_en,
    output logic [DW-1:0] pix_data,
    output logic          pix_valid,
    input  logic          pix_ready,
    input  logic [DW-1:0] res_data,
    input  logic          res_valid,
    output logic          res_ready,
    output logic          proto_err,
    output pio_state_t    dbg_state
);

    localparam int CNT_W = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETUP_CYC - 1);

    logic req_s;
    logic dir_s;

    io_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
        .clk_i (clk),
        .rst_i (reset),
        .d_i   (req_pad),
        .q_o   (req_s)
    );

    io_sync #(.STAGES(SYNC_STAGES)) u_dir_sync (
        .clk_i (clk),
        .rst_i (reset),
        .d_i   (dir_pad),
        .q_o   (dir_s)
    );

    pio_state_t       state_q, state_d;
    logic             ack_q, ack_d;
    logic             bus_en_q, bus_en_d;
    logic [DW-1:0]    bus_out_q, bus_out_d;
    logic [DW-1:0]    pix_data_q, pix_data_d;
    logic             pix_valid_q, pix_valid_d;
    logic             res_ready_q, res_ready_d;
    logic             proto_err_q, proto_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ack_q       <= 1'b0;
            bus_en_q    <= 1'b0;
            bus_out_q   <= '0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            res_ready_q <= 1'b0;
            proto_err_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            bus_en_q    <= bus_en_d;
            bus_out_q   <= bus_out_d;
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
            res_ready_q <= res_ready_d;
            proto_err_q <= proto_err_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ack_d       = ack_q;
        bus_en_d    = bus_en_q;
        bus_out_d   = bus_out_q;
        pix_data_d  = pix_data_q;
        pix_valid_d = pix_valid_q;
        res_ready_d = res_ready_q;
        proto_err_d = proto_err_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                // dir_s is only looked at here; later changes are ignored.
                if (req_s) begin
                    if (!dir_s) begin
                        pix_data_d  = bus_in;
                        pix_valid_d = 1'b1;
                        state_d     = WR_HOLD;
                    end else begin
                        res_ready_d = 1'b1;
                        state_d     = RD_WAIT;
                    end
                end
            end
            WR_HOLD: begin
                // The pixel is always delivered; an early req drop only
                // skips the ack phase.
                if (pix_valid_q && pix_ready) begin
                    pix_valid_d = 1'b0;
                    if (req_s) begin
                        ack_d   = 1'b1;
                        state_d = ACK_HI;
                    end else begin
                        proto_err_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            RD_WAIT: begin
                // A result offered on the same edge is taken before the
                // abort check so the core never loses a beat it handed over.
                if (res_valid && res_ready_q) begin
                    bus_out_d   = res_data;
                    bus_en_d    = 1'b1;
                    res_ready_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = RD_SETUP;
                end else if (!req_s) begin
                    proto_err_d = 1'b1;
                    res_ready_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            RD_SETUP: begin
                if (cnt_q == CNT_LAST) begin
                    ack_d   = 1'b1;
                    state_d = ACK_HI;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACK_HI: begin
                if (!req_s) begin
                    ack_d    = 1'b0;
                    bus_en_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ack_pad   = ack_q;
    assign bus_en    = bus_en_q;
    assign bus_out   = bus_out_q;
    assign pix_data  = pix_data_q;
    assign pix_valid = pix_valid_q;
    assign res_ready = res_ready_q;
    assign proto_err = proto_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pixel_io_ctrl.sv
// Directed testbench for pixel_io_ctrl: a table of write/read transfers
// with hand-computed results, then hand-written abort, reset and
// direction-change sequences.
module tb_pixel_io_ctrl;
    import pixel_io_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_pad;
    logic       dir_pad;
    logic       ack_pad;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       bus_en;
    logic [7:0] pix_data;
    logic       pix_valid;
    logic       pix_ready;
    logic [7:0] res_data;
    logic       res_valid;
    logic       res_ready;
    logic       proto_err;
    pio_state_t dbg_state;

    int checks = 0;
    int errors = 0;

    pixel_io_ctrl #(.DW(8), .SYNC_STAGES(2), .SETUP_CYC(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_pad   (req_pad),
        .dir_pad   (dir_pad),
        .ack_pad   (ack_pad),
        .bus_in    (bus_in),
        .bus_out   (bus_out),
        .bus_en    (bus_en),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .proto_err (proto_err),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // Advance one edge; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- comparison helpers ----------------
    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Host write: pixel appears 3 edges after req rises, ack 1 edge after
    // the pixel handshake, ack falls 3 edges after req falls.
    task automatic do_write(input logic [7:0] din, input int dly, input logic [7:0] exp);
        dir_pad   = 1'b0;
        bus_in    = din;
        pix_ready = (dly == 0);
        req_pad   = 1'b1;
        tick(); tick();
        chk1("wr_valid_early", pix_valid, 1'b0);
        tick();
        chk1("wr_valid_e3", pix_valid, 1'b1);
        chk8("wr_data_e3", pix_data, exp);
        chk1("wr_ack_e3", ack_pad, 1'b0);
        for (int i = 0; i < dly; i++) begin
            tick();
            chk1("wr_bp_valid", pix_valid, 1'b1);
            chk8("wr_bp_data", pix_data, exp);
            chk1("wr_bp_ack", ack_pad, 1'b0);
        end
        pix_ready = 1'b1;
        tick();
        chk1("wr_valid_hs", pix_valid, 1'b0);
        chk1("wr_ack_hs", ack_pad, 1'b1);
        chk1("wr_en_hs", bus_en, 1'b0);
        pix_ready = 1'b0;
        req_pad   = 1'b0;
        tick(); tick();
        chk1("wr_ack_hold", ack_pad, 1'b1);
        tick();
        chk1("wr_ack_rel", ack_pad, 1'b0);
        chk8("wr_state_rel", 8'(dbg_state), 8'(IDLE));
    endtask

    // Host read: res_ready 3 edges after req, bus_en 1 edge after the
    // result handshake, ack 2 edges after bus_en, both fall together.
    task automatic do_read(input logic [7:0] rdat, input int dly, input logic [7:0] exp);
        dir_pad   = 1'b1;
        res_valid = 1'b0;
        res_data  = rdat;
        req_pad   = 1'b1;
        tick(); tick();
        chk1("rd_ready_early", res_ready, 1'b0);
        tick();
        chk1("rd_ready_e3", res_ready, 1'b1);
        chk1("rd_en_e3", bus_en, 1'b0);
        for (int i = 0; i < dly; i++) begin
            tick();
            chk1("rd_wait_ready", res_ready, 1'b1);
            chk1("rd_wait_en", bus_en, 1'b0);
        end
        res_valid = 1'b1;
        tick();
        chk1("rd_en_hs", bus_en, 1'b1);
        chk8("rd_data_hs", bus_out, exp);
        chk1("rd_ready_hs", res_ready, 1'b0);
        chk1("rd_ack_hs", ack_pad, 1'b0);
        res_valid = 1'b0;
        tick();
        chk1("rd_ack_setup", ack_pad, 1'b0);
        tick();
        chk1("rd_ack_up", ack_pad, 1'b1);
        chk1("rd_en_ack", bus_en, 1'b1);
        req_pad = 1'b0;
        tick(); tick();
        chk1("rd_ack_hold", ack_pad, 1'b1);
        chk1("rd_en_hold", bus_en, 1'b1);
        tick();
        chk1("rd_ack_rel", ack_pad, 1'b0);
        chk1("rd_en_rel", bus_en, 1'b0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       dir;
        logic [7:0] din;
        int         dly;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic en_seen;

        vecs[0] = '{dir: 1'b0, din: 8'hA5, dly: 0,  exp: 8'hA5};
        vecs[1] = '{dir: 1'b0, din: 8'hA5, dly: 10, exp: 8'hA5};
        vecs[2] = '{dir: 1'b1, din: 8'h3C, dly: 0,  exp: 8'h3C};
        vecs[3] = '{dir: 1'b0, din: 8'h00, dly: 2,  exp: 8'h00};
        vecs[4] = '{dir: 1'b1, din: 8'hFF, dly: 3,  exp: 8'hFF};
        vecs[5] = '{dir: 1'b0, din: 8'h5A, dly: 1,  exp: 8'h5A};

        reset     = 1'b1;
        req_pad   = 1'b0;
        dir_pad   = 1'b0;
        bus_in    = 8'h00;
        pix_ready = 1'b0;
        res_data  = 8'h00;
        res_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();

        chk1("rst_ack", ack_pad, 1'b0);
        chk1("rst_en", bus_en, 1'b0);
        chk8("rst_bus_out", bus_out, 8'h00);
        chk8("rst_pix_data", pix_data, 8'h00);
        chk1("rst_pix_valid", pix_valid, 1'b0);
        chk1("rst_res_ready", res_ready, 1'b0);
        chk1("rst_proto_err", proto_err, 1'b0);
        chk8("rst_state", 8'(dbg_state), 8'(IDLE));

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].dir) do_read(vecs[v].din, vecs[v].dly, vecs[v].exp);
            else             do_write(vecs[v].din, vecs[v].dly, vecs[v].exp);
        end
        chk1("table_proto_err", proto_err, 1'b0);

        // Read abort: req dropped while waiting for a result.
        en_seen  = 1'b0;
        dir_pad  = 1'b1;
        req_pad  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            en_seen = en_seen | bus_en;
        end
        chk1("abort_ready_up", res_ready, 1'b1);
        req_pad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            en_seen = en_seen | bus_en;
        end
        chk1("abort_proto_err", proto_err, 1'b1);
        chk1("abort_res_ready", res_ready, 1'b0);
        chk8("abort_state", 8'(dbg_state), 8'(IDLE));
        chk1("abort_en_never", en_seen, 1'b0);
        tick();
        chk1("abort_err_sticky", proto_err, 1'b1);

        // Reset while the read data is being set up on the bus.
        dir_pad   = 1'b1;
        res_data  = 8'h96;
        req_pad   = 1'b1;
        tick(); tick(); tick();
        res_valid = 1'b1;
        tick();
        chk1("rs_en_before", bus_en, 1'b1);
        chk8("rs_state_setup", 8'(dbg_state), 8'(RD_SETUP));
        res_valid = 1'b0;
        req_pad   = 1'b0;
        reset     = 1'b1;
        #1;
        chk1("rs_en_async", bus_en, 1'b0);
        chk1("rs_ack_async", ack_pad, 1'b0);
        chk1("rs_err_async", proto_err, 1'b0);
        chk8("rs_bus_out_async", bus_out, 8'h00);
        tick();
        reset = 1'b0;
        tick();
        do_write(8'h01, 0, 8'h01);
        chk1("rs_err_after", proto_err, 1'b0);

        // Direction change while ack is high must not affect the transfer.
        dir_pad   = 1'b0;
        bus_in    = 8'hC3;
        pix_ready = 1'b1;
        req_pad   = 1'b1;
        tick(); tick(); tick(); tick();
        chk1("dt_ack_up", ack_pad, 1'b1);
        pix_ready = 1'b0;
        dir_pad   = 1'b1;
        tick(); tick(); tick();
        chk1("dt_ack_hold", ack_pad, 1'b1);
        chk1("dt_en_low", bus_en, 1'b0);
        chk1("dt_ready_low", res_ready, 1'b0);
        chk8("dt_state", 8'(dbg_state), 8'(ACK_HI));
        dir_pad = 1'b0;
        req_pad = 1'b0;
        tick(); tick(); tick();
        chk1("dt_ack_rel", ack_pad, 1'b0);
        do_write(8'h77, 0, 8'h77);
        chk1("dt_next_en", bus_en, 1'b0);

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
